csa_word_scheduler: RTL

//  Shares one 8-bit conditional_sum_adder between two requesters and sequences NBYTES-wide additions

---
 rtl/csa_seq_pkg.sv | 14 +
 rtl/conditional_sum_adder.sv | 48 ++++
 rtl/csa_rr_arb2.sv | 18 +
 rtl/csa_word_scheduler.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/csa_seq_pkg.sv
// Shared definitions for the byte-serial adder scheduler: FSM encoding,
// datapath byte width and requester count.
package csa_seq_pkg;

    localparam int BYTE_W = 8;
    localparam int NREQ   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/conditional_sum_adder.sv
// Combinational conditional-sum adder: per-bit sum/carry pairs for both carry-in
// assumptions are merged in log2(WIDTH) levels. WIDTH must be a power of two.
module conditional_sum_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int LVLS = $clog2(WIDTH);

    // s0/s1: sums assuming block carry-in 0/1; c0/c1: carry out of the block
    // whose lowest bit is the index.
    always_comb begin
        logic [WIDTH-1:0] s0, s1, c0, c1;
        logic [WIDTH-1:0] n0, n1, m0, m1;
        for (int i = 0; i < WIDTH; i++) begin
            s0[i] = x[i] ^ y[i];
            s1[i] = ~(x[i] ^ y[i]);
            c0[i] = x[i] & y[i];
            c1[i] = x[i] | y[i];
        end
        for (int lvl = 0; lvl < LVLS; lvl++) begin
            n0 = s0;
            n1 = s1;
            m0 = c0;
            m1 = c1;
            for (int b = 0; b < WIDTH; b += (2 << lvl)) begin
                for (int j = b + (1 << lvl); j < b + (2 << lvl); j++) begin
                    n0[j] = c0[b] ? s1[j] : s0[j];
                    n1[j] = c1[b] ? s1[j] : s0[j];
                end
                m0[b] = c0[b] ? c1[b + (1 << lvl)] : c0[b + (1 << lvl)];
                m1[b] = c1[b] ? c1[b + (1 << lvl)] : c0[b + (1 << lvl)];
            end
            s0 = n0;
            s1 = n1;
            c0 = m0;
            c1 = m1;
        end
        sum  = cin ? s1 : s0;
        cout = cin ? c1[0] : c0[0];
    end

endmodule

// File: rtl/csa_rr_arb2.sv
// Two-way round-robin arbiter: a lone valid requester always wins; on contention
// the pointer picks the winner.
module csa_rr_arb2
    import csa_seq_pkg::*;
(
    input  logic [NREQ-1:0] valid,
    input  logic            ptr,
    output logic [NREQ-1:0] grant
);

    always_comb begin
        grant = valid;
        if (&valid) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/csa_word_scheduler.sv
// Shares one 8-bit conditional-sum adder between two requesters, adding NBYTES-wide
// operands LSB byte first. Optional subtract support is enabled by defining CSA_SUB_EN.
module csa_word_scheduler
    import csa_seq_pkg::*;
#(
    parameter  int NBYTES = 4,
    localparam int W      = BYTE_W * NBYTES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    input  logic [NREQ-1:0]     req_cin,
`ifdef CSA_SUB_EN
    input  logic [NREQ-1:0]     req_sub,
`endif
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [W-1:0]        rsp_sum,
    output logic                rsp_cout
);

    localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [KW-1:0]     k_q, k_d;
    logic              carry_q, carry_d;
    logic              id_q, id_d;
    logic [W-1:0]      sum_q, sum_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic              cin_q, cin_d;

    logic [NREQ-1:0]   grant;
    logic              grant_id;
    logic              accept;
    logic [KW+2:0]     byte_off;
    logic [BYTE_W-1:0] add_x, add_y, add_sum;
    logic              add_cin, add_cout;

    // While reset is held the ready outputs already behave as IDLE with ptr = 0.
    csa_rr_arb2 u_arb (
        .valid (req_valid),
        .ptr   (rst_n ? ptr_q : 1'b0),
        .grant (grant)
    );

    assign req_ready = (state_q == ST_IDLE || !rst_n) ? grant : '0;
    assign grant_id  = req_ready[1];
    assign accept    = |(req_valid & req_ready);

    assign byte_off = {k_q, 3'b000};
    assign add_x    = a_q[byte_off +: BYTE_W];
    assign add_y    = b_q[byte_off +: BYTE_W];
    assign add_cin  = (k_q == '0) ? cin_q : carry_q;

    conditional_sum_adder #(.WIDTH(BYTE_W)) u_add (
        .x    (add_x),
        .y    (add_y),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        k_d     = k_q;
        carry_d = carry_q;
        id_d    = id_q;
        sum_d   = sum_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = grant_id ? req_a[W +: W] : req_a[W-1:0];
                    b_d     = grant_id ? req_b[W +: W] : req_b[W-1:0];
                    cin_d   = req_cin[grant_id];
`ifdef CSA_SUB_EN
                    if (req_sub[grant_id]) begin
                        b_d   = ~b_d;
                        cin_d = 1'b1;
                    end
`endif
                    id_d    = grant_id;
                    ptr_d   = ~grant_id;
                    k_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[byte_off +: BYTE_W] = add_sum;
                carry_d = add_cout;
                if (k_q == K_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            k_q     <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
        end
    end

    // Operand latches are only meaningful after an accept, so they skip reset.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        cin_q <= cin_d;
    end

    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = carry_q;

endmodule
